imem_program_loader: RTL and testbench

//  Front-end loader feeding the CPU instruction-memory write port (I_MEM_Write_Enable/Data_In/Write_Addr)
//  and the CPU start input. Accepts a byte stream (valid/ready): 16-bit word count, big-endian 32-bit

---
 rtl/imem_program_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_program_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: takes a byte stream and loads it into instruction memory, then starts the CPU.
// Stream format: 16-bit word count (high byte first), big-endian 32-bit words, then a 1-byte XOR checksum.
// Ports: clk, rst (async active-low), load_go, byte_valid/byte_data/byte_ready (stream handshake),
//   i_mem_we/i_mem_data/i_mem_addr (imem write port), cpu_start, busy, done, err.
module imem_program_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_go,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        i_mem_we,
  output logic [31:0] i_mem_data,
  output logic [15:0] i_mem_addr,
  output logic        cpu_start,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK, S_START, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  nbyte_q, nbyte_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] hdr_count;
  logic        loading;

  assign accept = byte_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    nbyte_d   = nbyte_q;
    word_d    = word_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    we_d      = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    start_d   = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    hdr_count = {count_q[15:8], byte_data};
    loading   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_go) begin
          state_d = S_HDR_HI;
          count_d = '0;
          idx_d   = '0;
          nbyte_d = '0;
          word_d  = '0;
          csum_d  = '0;
          tmo_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_HDR_HI: begin
        loading = 1'b1;
        if (accept) begin
          count_d = {byte_data, 8'h00};
          csum_d  = csum_q ^ byte_data;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        loading = 1'b1;
        if (accept) begin
          count_d = hdr_count;
          csum_d  = csum_q ^ byte_data;
          if (32'(hdr_count) > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (hdr_count == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        loading = 1'b1;
        if (accept) begin
          csum_d  = csum_q ^ byte_data;
          word_d  = {word_q[23:0], byte_data};
          nbyte_d = nbyte_q + 2'd1;
          if (nbyte_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = {word_q[23:0], byte_data};
            addr_d = BASE_ADDR + idx_q;
            idx_d  = idx_q + 16'd1;
            if (idx_d == count_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        loading = 1'b1;
        if (accept) begin
          if (byte_data == csum_q) begin
            state_d = S_START;
            start_d = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle-cycle watchdog shared by all byte-accepting states; an abort never
    // coincides with a write because writes only follow an accepted byte.
    if (loading) begin
      if (accept) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_d >= TIMEOUT_CYCLES) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
    end

    ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
              (state_d == S_DATA)   || (state_d == S_CHECK);
    busy_d  = ready_d || (state_d == S_START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      nbyte_q <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      nbyte_q <= nbyte_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready = ready_q;
  assign i_mem_we   = we_q;
  assign i_mem_data = data_q;
  assign i_mem_addr = addr_q;
  assign cpu_start  = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_go = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        i_mem_we;
  logic [31:0] i_mem_data;
  logic [15:0] i_mem_addr;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic        err;

  imem_program_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_go    (load_go),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .i_mem_we   (i_mem_we),
    .i_mem_data (i_mem_data),
    .i_mem_addr (i_mem_addr),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] stream[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         start_cnt = 0;
  logic       prev_start = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the expected write for every strobe and tracks start pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_start) check("done_after_start", {62'd0, done, cpu_start}, 64'b10);
      prev_start = cpu_start;
      if (cpu_start) start_cnt++;
      if (i_mem_we) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", i_mem_addr, i_mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {16'd0, i_mem_addr, i_mem_data}, {16'd0, mon_e.addr, mon_e.data});
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic pulse_go();
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_wait: got ready %b, required 1", byte_ready);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  // Reference model: derives writes and outcome from the stream contents alone.
  task automatic model(output bit hdr_err, output bit ok);
    int unsigned cnt;
    logic [7:0]  x;
    cnt = {stream[0], stream[1]};
    hdr_err = (cnt > MAXW);
    ok = 1'b0;
    if (!hdr_err) begin
      for (int unsigned i = 0; i < cnt; i++)
        exp_q.push_back('{addr: BASE + 16'(i),
                          data: {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]}});
      x = 8'h00;
      for (int i = 0; i < stream.size() - 1; i++) x = x ^ stream[i];
      ok = (x == stream[stream.size()-1]);
    end
  endtask

  task automatic run_stream(input int max_gap, input bit hold_go);
    bit hdr_err, ok;
    int s0, nsend, n;
    model(hdr_err, ok);
    s0 = start_cnt;
    load_go = 1'b1;
    @(negedge clk);
    if (!hold_go) load_go = 1'b0;
    check("busy_after_go", {63'd0, busy}, 64'd1);
    nsend = hdr_err ? 2 : stream.size();
    for (int i = 0; i < nsend; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(stream[i]);
    end
    load_go = 1'b0;
    if (hdr_err) check("hdr_err_ready", {62'd0, err, byte_ready}, 64'b10);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", {63'd0, busy}, 64'd0);
    check("done_err", {62'd0, done, err}, (ok && !hdr_err) ? 64'b10 : 64'b01);
    check("start_pulses", 64'(start_cnt - s0), (ok && !hdr_err) ? 64'd1 : 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic case1_stream();
    stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
  endtask

  initial begin
    #1;
    check("reset_outputs", {10'd0, byte_ready, i_mem_we, i_mem_data, i_mem_addr, cpu_start, busy, done, err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Two words, good checksum
    case1_stream();
    run_stream(0, 1'b0);

    // Same stream, bad checksum
    case1_stream();
    stream[10] = 8'h47;
    run_stream(0, 1'b0);

    // Empty program
    stream = '{8'h00, 8'h00, 8'h00};
    run_stream(0, 1'b0);

    // Header above MAX_WORDS
    stream = '{8'h04, 8'h01};
    run_stream(0, 1'b0);

    // Timeout mid-word: partial word must not be written
    pulse_go();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_yet", {62'd0, busy, err}, 64'b10);
    @(negedge clk);
    check("tmo_abort", {60'd0, busy, err, done, byte_ready}, 64'b0100);
    repeat (3) @(negedge clk);

    // Reset mid-load
    pulse_go();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b0;
    #1;
    check("midload_reset", {10'd0, byte_ready, i_mem_we, i_mem_data, i_mem_addr, cpu_start, busy, done, err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    case1_stream();
    run_stream(0, 1'b0);

    // Randomized loads with gaps, corrupted checksums and load_go held during busy
    for (int unsigned it = 0; it < 12; it++) begin
      int unsigned cnt;
      logic [7:0]  x;
      logic [31:0] w;
      cnt = $urandom_range(0, 5);
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'(cnt));
      for (int unsigned k = 0; k < cnt; k++) begin
        w = $urandom;
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
      end
      x = 8'h00;
      for (int k = 0; k < stream.size(); k++) x = x ^ stream[k];
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      stream.push_back(x);
      run_stream(3, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
